// File: rtl/pipe_pkg.sv
// Shared types for the multi-channel pipelined accumulator.
package pipe_pkg;

    localparam int W_OP = 2;

    typedef enum logic [W_OP-1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_LOAD = 2'd2,
        OP_READ = 2'd3
    } op_e;

endpackage

// File: rtl/pipe_acc_if.sv
// Request and result handshake bus of pipe_acc; slave is the accumulator side.
interface pipe_acc_if #(
    parameter int W_DATA = 32,
    parameter int N_CH   = 4,
    parameter int W_CNT  = 16
);
    import pipe_pkg::*;

    localparam int W_CH = $clog2(N_CH);

    logic              i_valid;
    logic              o_ready;
    logic [W_CH-1:0]   i_ch;
    op_e               i_op;
    logic [W_DATA-1:0] i_data;
    logic              o_valid;
    logic              i_ready;
    logic [W_CH-1:0]   o_ch;
    logic [W_DATA-1:0] o_data;
    logic              o_ovf;
    logic [W_CNT-1:0]  o_count;

    modport slave (
        input  i_valid, i_ch, i_op, i_data, i_ready,
        output o_ready, o_valid, o_ch, o_data, o_ovf, o_count
    );

    modport master (
        output i_valid, i_ch, i_op, i_data, i_ready,
        input  o_ready, o_valid, o_ch, o_data, o_ovf, o_count
    );

endinterface

// File: rtl/pipe_fifo.sv
// Synchronous valid/ready FIFO; outputs read as zero while empty.
module pipe_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_ready = (count != CNT_W'(DEPTH));
    assign o_valid = (count != '0);
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;
    assign o_data  = o_valid ? mem[rd_ptr] : '0;
    assign o_count = count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the count gates what is visible.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_data;
    end

endmodule

// File: rtl/pipe_acc.sv
// Multi-channel accumulator: request register (S1), read-modify-write of the
// channel accumulator with push into the output buffer (S2).
module pipe_acc
    import pipe_pkg::*;
#(
    parameter int W_DATA    = 32,
    parameter int N_CH      = 4,
    parameter bit SATURATE  = 1'b0,
    parameter int OUT_DEPTH = 4,
    parameter int W_CNT     = 16
) (
    input logic      i_clk,
    input logic      i_rst,
    pipe_acc_if.slave bus
);

    localparam int W_CH  = $clog2(N_CH);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam logic [W_DATA-1:0] MAX_V = {1'b0, {(W_DATA-1){1'b1}}};
    localparam logic [W_DATA-1:0] MIN_V = {1'b1, {(W_DATA-1){1'b0}}};

    typedef struct packed {
        logic [W_CH-1:0]   ch;
        logic [W_DATA-1:0] data;
        logic              ovf;
    } result_t;

    logic [W_DATA-1:0] acc [N_CH];
    logic              s1_valid;
    logic [W_CH-1:0]   s1_ch;
    op_e               s1_op;
    logic [W_DATA-1:0] s1_data;
    logic [W_CNT-1:0]  count;

    logic              accept;
    logic              fifo_ready;
    logic              s2_go;
    logic [CNT_W-1:0]  fifo_count;
    logic              ch_ok;
    logic [W_DATA:0]   wide;
    result_t           s2_res;
    result_t           fifo_out;

    // Occupancy uses registered state only, so a same-cycle pop is never credited.
    assign bus.o_ready = !i_rst &&
                         ((32'(fifo_count) + 32'(s1_valid)) < 32'(OUT_DEPTH));
    assign accept      = bus.i_valid && bus.o_ready;
    assign s2_go       = s1_valid && fifo_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            count    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) count <= count + W_CNT'(1);
        end
        if (accept) begin
            s1_ch   <= bus.i_ch;
            s1_op   <= bus.i_op;
            s1_data <= bus.i_data;
        end
    end

    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch forms.
    always_comb begin
        ch_ok  = (32'(s1_ch) < 32'(N_CH));
        wide   = '0;
        s2_res = '0;
        s2_res.ch = s1_ch;
        if (ch_ok) begin
            unique case (s1_op)
                OP_ADD:  wide = {acc[s1_ch][W_DATA-1], acc[s1_ch]} + {s1_data[W_DATA-1], s1_data};
                OP_SUB:  wide = {acc[s1_ch][W_DATA-1], acc[s1_ch]} - {s1_data[W_DATA-1], s1_data};
                OP_LOAD: wide = {s1_data[W_DATA-1], s1_data};
                default: wide = {acc[s1_ch][W_DATA-1], acc[s1_ch]};
            endcase
            // One extra sign bit disagreeing with the result MSB marks signed overflow.
            s2_res.ovf  = wide[W_DATA] != wide[W_DATA-1];
            s2_res.data = wide[W_DATA-1:0];
            if (s2_res.ovf && SATURATE) s2_res.data = wide[W_DATA] ? MIN_V : MAX_V;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_CH; i++) acc[i] <= '0;
        end else if (s2_go && ch_ok) begin
            acc[s1_ch] <= s2_res.data;
        end
    end

    pipe_fifo #(
        .WIDTH ($bits(result_t)),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (s1_valid),
        .o_ready (fifo_ready),
        .i_data  (s2_res),
        .o_valid (bus.o_valid),
        .i_ready (bus.i_ready),
        .o_data  (fifo_out),
        .o_count (fifo_count)
    );

    assign bus.o_ch    = fifo_out.ch;
    assign bus.o_data  = fifo_out.data;
    assign bus.o_ovf   = fifo_out.ovf;
    assign bus.o_count = count;

endmodule

// File: tb/tb_pipe_acc.sv
// Randomized bench for pipe_acc: a 32-bit wrapping instance and an 8-bit
// saturating 3-channel instance, both scored against an arithmetic model.
module tb_pipe_acc;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_acc_if #(.W_DATA(32), .N_CH(4), .W_CNT(16)) ifa ();
    pipe_acc_if #(.W_DATA(8),  .N_CH(3), .W_CNT(4))  ifb ();

    pipe_acc #(.W_DATA(32), .N_CH(4), .SATURATE(1'b0), .OUT_DEPTH(4), .W_CNT(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(ifa.slave));
    pipe_acc #(.W_DATA(8), .N_CH(3), .SATURATE(1'b1), .OUT_DEPTH(3), .W_CNT(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .bus(ifb.slave));

    function automatic int wd(input int k);    return (k == 0) ? 32 : 8; endfunction
    function automatic int nch(input int k);   return (k == 0) ? 4 : 3;  endfunction
    function automatic int depth(input int k); return (k == 0) ? 4 : 3;  endfunction
    function automatic int wcnt(input int k);  return (k == 0) ? 16 : 4; endfunction
    function automatic bit sat(input int k);   return k != 0;            endfunction

    typedef struct {
        int     ch;
        int     op;
        longint data;
        bit     ovf;
        longint stamp;
    } exp_t;

    exp_t   rb [2][64];
    int     head [2] = '{0, 0};
    int     tail [2] = '{0, 0};
    longint acc [2][4];
    longint cnt [2] = '{0, 0};
    int     accepts [2] = '{0, 0};
    int     pops [2] = '{0, 0};
    longint last_data [2];
    bit     last_ovf [2];
    longint read_val [2][4];
    bit     rnd_ready [2] = '{1'b0, 1'b0};
    longint cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply one operation to the reference accumulators with the signed-range rules.
    task automatic model_op(input int k, input int ch, input int op, input longint d,
                            output longint r, output bit ovf);
        longint mx = (longint'(1) <<< (wd(k) - 1)) - 1;
        longint mn = -mx - 1;
        ovf = 1'b0;
        r   = 0;
        if (ch < nch(k)) begin
            case (op)
                0:       r = acc[k][ch] + d;
                1:       r = acc[k][ch] - d;
                2:       r = d;
                default: r = acc[k][ch];
            endcase
            if (r > mx || r < mn) begin
                ovf = 1'b1;
                if (sat(k)) r = (r > mx) ? mx : mn;
                else        r = (r > mx) ? r - 2 * (mx + 1) : r + 2 * (mx + 1);
            end
            acc[k][ch] = r;
        end
    endtask

    task automatic mon(input int k, input bit v, input bit rdy, input bit ov, input bit irdy,
                       input int ch, input int op, input longint din,
                       input int och, input longint od, input bit oo, input longint oc);
        exp_t   e;
        longint r;
        bit     ovf;
        bit     expv;
        if (rst) begin
            check($sformatf("ready_in_reset%0d", k), longint'(rdy), 0);
            head[k] = 0;
            tail[k] = 0;
            cnt[k]  = 0;
            for (int c = 0; c < 4; c++) acc[k][c] = 0;
        end else begin
            check($sformatf("ready%0d", k), longint'(rdy), longint'((tail[k] - head[k]) < depth(k)));
            check($sformatf("count%0d", k), oc, cnt[k] % (longint'(1) <<< wcnt(k)));
            e    = rb[k][head[k] % 64];
            expv = (tail[k] != head[k]) && (cyc >= e.stamp + 1);
            check($sformatf("valid%0d", k), longint'(ov), longint'(expv));
            if (ov && expv && irdy) begin
                check($sformatf("o_ch%0d", k), och, e.ch);
                check($sformatf("o_data%0d", k), od, e.data);
                check($sformatf("o_ovf%0d", k), longint'(oo), longint'(e.ovf));
                last_data[k] = od;
                last_ovf[k]  = oo;
                if (e.op == 3 && e.ch < 4) read_val[k][e.ch] = od;
                head[k]++;
                pops[k]++;
            end
            if (v && rdy) begin
                model_op(k, ch, op, din, r, ovf);
                e = '{ch: ch, op: op, data: r, ovf: ovf, stamp: cyc + 1};
                rb[k][tail[k] % 64] = e;
                tail[k]++;
                cnt[k]++;
                accepts[k]++;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, ifa.i_valid, ifa.o_ready, ifa.o_valid, ifa.i_ready, int'(ifa.i_ch), int'(ifa.i_op),
            longint'($signed(ifa.i_data)), int'(ifa.o_ch), longint'($signed(ifa.o_data)),
            ifa.o_ovf, longint'(ifa.o_count));
        mon(1, ifb.i_valid, ifb.o_ready, ifb.o_valid, ifb.i_ready, int'(ifb.i_ch), int'(ifb.i_op),
            longint'($signed(ifb.i_data)), int'(ifb.o_ch), longint'($signed(ifb.o_data)),
            ifb.o_ovf, longint'(ifb.o_count));
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready[0]) ifa.i_ready = 1'($urandom_range(0, 1));
        if (rnd_ready[1]) ifb.i_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input bit v, input int ch, input int op, input longint d);
        if (k == 0) begin
            ifa.i_valid = v; ifa.i_ch = 2'(ch); ifa.i_op = op_e'(2'(op)); ifa.i_data = 32'(d);
        end else begin
            ifb.i_valid = v; ifb.i_ch = 2'(ch); ifb.i_op = op_e'(2'(op)); ifb.i_data = 8'(d);
        end
    endtask

    task automatic set_ready(input int k, input bit r);
        rnd_ready[k] = 1'b0;
        if (k == 0) ifa.i_ready = r;
        else        ifb.i_ready = r;
    endtask

    task automatic send(input int k, input int ch, input int op, input longint d);
        bit got = 1'b0;
        drive(k, 1'b1, ch, op, d);
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = (k == 0) ? ifa.o_ready : ifb.o_ready;
            @(posedge clk);
            #1;
        end
        if (!got) check("send_timeout", longint'(got), 1);
        drive(k, 1'b0, 0, 0, 0);
    endtask

    task automatic drain(input int k);
        set_ready(k, 1'b1);
        for (int i = 0; i < 300 && head[k] != tail[k]; i++) tick(1);
        check($sformatf("drain%0d", k), longint'(tail[k] - head[k]), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int a0;
        int p0;
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        set_ready(0, 1'b1);
        set_ready(1, 1'b1);
        tick(3);
        check("rst_valid", longint'(ifa.o_valid), 0);
        check("rst_data", longint'(ifa.o_data), 0);
        check("rst_ch", longint'(ifa.o_ch), 0);
        check("rst_ovf", longint'(ifa.o_ovf), 0);
        check("rst_count", longint'(ifa.o_count), 0);
        rst = 1'b0;

        // Chained ops on one channel, then 32-bit wrap overflow.
        send(0, 1, 2, 5);
        send(0, 1, 0, 3);
        send(0, 1, 1, 10);
        drain(0);
        check("t1_count", longint'(ifa.o_count), 3);
        check("t1_last", last_data[0], -2);
        send(0, 2, 2, 64'h7fff_ffff);
        send(0, 2, 0, 1);
        drain(0);
        check("wrap_data", last_data[0], -64'sd2147483648);
        check("wrap_ovf", longint'(last_ovf[0]), 1);

        // Back-pressure: exactly OUT_DEPTH accepts, then ordered drain.
        do_reset();
        set_ready(0, 1'b0);
        a0 = accepts[0];
        p0 = pops[0];
        drive(0, 1'b1, 0, 0, 1);
        tick(12);
        check("bp_accepts", longint'(accepts[0] - a0), 4);
        check("bp_ready", longint'(ifa.o_ready), 0);
        drive(0, 1'b0, 0, 0, 0);
        drain(0);
        check("bp_pops", longint'(pops[0] - p0), 4);

        // Interleaved ADD 1 on all channels with random output stalls.
        do_reset();
        rnd_ready[0] = 1'b1;
        for (int i = 0; i < 100; i++) send(0, i % 4, 0, 1);
        for (int c = 0; c < 4; c++) send(0, c, 3, 0);
        drain(0);
        for (int c = 0; c < 4; c++) check($sformatf("il_read%0d", c), read_val[0][c], 25);
        check("il_count", longint'(ifa.o_count), 104);

        // Reset with results in flight and buffered.
        set_ready(0, 1'b0);
        send(0, 0, 0, 7);
        send(0, 1, 0, 8);
        send(0, 2, 0, 9);
        rst = 1'b1;
        tick(1);
        check("mid_rst_valid", longint'(ifa.o_valid), 0);
        check("mid_rst_count", longint'(ifa.o_count), 0);
        rst = 1'b0;
        set_ready(0, 1'b1);
        for (int c = 0; c < 4; c++) read_val[0][c] = -1;
        for (int c = 0; c < 4; c++) send(0, c, 3, 0);
        drain(0);
        for (int c = 0; c < 4; c++) check($sformatf("post_rst_read%0d", c), read_val[0][c], 0);

        // Sustained throughput with the output always ready.
        a0 = accepts[0];
        drive(0, 1'b1, 3, 0, 7);
        tick(20);
        drive(0, 1'b0, 0, 0, 0);
        check("throughput", longint'(accepts[0] - a0), 20);
        drain(0);

        // Random traffic on the 32-bit instance.
        rnd_ready[0] = 1'b1;
        for (int i = 0; i < 300; i++)
            send(0, $urandom_range(0, 3), $urandom_range(0, 3), longint'($signed($urandom())));
        drain(0);

        // Saturating 8-bit instance: clamps, out-of-range channel, counter wrap.
        do_reset();
        send(1, 0, 2, 127);
        send(1, 0, 0, 1);
        drain(1);
        check("sat_hi_data", last_data[1], 127);
        check("sat_hi_ovf", longint'(last_ovf[1]), 1);
        send(1, 1, 2, -128);
        send(1, 1, 1, 1);
        drain(1);
        check("sat_lo_data", last_data[1], -128);
        check("sat_lo_ovf", longint'(last_ovf[1]), 1);
        send(1, 3, 2, 55);
        send(1, 3, 3, 0);
        drain(1);
        check("bad_ch_data", last_data[1], 0);
        check("bad_ch_ovf", longint'(last_ovf[1]), 0);
        do_reset();
        for (int i = 0; i < 17; i++) send(1, i % 3, 0, 1);
        drain(1);
        check("cnt_wrap", longint'(ifb.o_count), 1);
        rnd_ready[1] = 1'b1;
        for (int i = 0; i < 200; i++)
            send(1, $urandom_range(0, 3), $urandom_range(0, 3), longint'($urandom_range(0, 255)) - 128);
        drain(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
